// File: rtl/x86_regctl_pkg.sv
// Shared types for the 8-bit register-file sequencer: opcodes, FSM states,
// register indices and the ALU result bundle.
package x86_regctl_pkg;

  typedef enum logic [2:0] {
    OP_MOV  = 3'd0,
    OP_MOVI = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_INC  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [2:0] REG_AX = 3'd0;
  localparam logic [2:0] REG_BX = 3'd1;
  localparam logic [2:0] REG_CX = 3'd2;
  localparam logic [2:0] REG_DX = 3'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       zf;
    logic       cf;
    logic       sf;
  } alu_res_t;

endpackage

// File: rtl/x86_alu8.sv
// Combinational 8-bit ALU. ZF/SF always reflect the result; the caller decides
// whether to commit them. CF passes cf_in through for ops that leave it alone.
module x86_alu8
  import x86_regctl_pkg::*;
(
  input  op_e        op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  input  logic       cf_in,
  output alu_res_t   res
);

  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [8:0] inc_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign inc_s  = {1'b0, a} + 9'd1;

  // Result and carry selection per opcode; bit 8 of diff_s is the borrow
  always_comb begin
    res.data = 8'd0;
    res.cf   = cf_in;
    case (op)
      OP_MOV:  begin res.data = b;           res.cf = cf_in;     end
      OP_MOVI: begin res.data = imm;         res.cf = cf_in;     end
      OP_ADD:  begin res.data = sum_s[7:0];  res.cf = sum_s[8];  end
      OP_SUB:  begin res.data = diff_s[7:0]; res.cf = diff_s[8]; end
      OP_AND:  begin res.data = a & b;       res.cf = 1'b0;      end
      OP_OR:   begin res.data = a | b;       res.cf = 1'b0;      end
      OP_XOR:  begin res.data = a ^ b;       res.cf = 1'b0;      end
      OP_INC:  begin res.data = inc_s[7:0];  res.cf = cf_in;     end
      default: begin res.data = 8'd0;        res.cf = cf_in;     end
    endcase
    res.zf = (res.data == 8'd0);
    res.sf = res.data[7];
  end

endmodule

// File: rtl/x86_regfile_sequencer.sv
// Sequences one micro-op at a time through READ/EXEC/WRITE/RESP against an
// external AX/BX/CX/DX register file; every output is registered.
module x86_regfile_sequencer
  import x86_regctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [2:0] req_dst,
  input  logic [2:0] req_src,
  input  logic [7:0] req_imm,
  output logic [2:0] read_addr1,
  output logic [2:0] read_addr2,
  input  logic [7:0] read_data1,
  input  logic [7:0] read_data2,
  output logic [7:0] write_data1,
  output logic [7:0] write_data2,
  output logic [7:0] write_data3,
  output logic       we1,
  output logic       we2,
  output logic       we3,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       flag_zf,
  output logic       flag_cf,
  output logic       flag_sf
);

  state_e     state_r;
  op_e        op_r;
  logic [2:0] dst_r;
  logic [2:0] src_r;
  logic [7:0] imm_r;
  logic [7:0] opa_r;
  logic [7:0] opb_r;
  logic [7:0] result_r;
  alu_res_t   alu_s;

  x86_alu8 u_alu (
    .op    (op_r),
    .a     (opa_r),
    .b     (opb_r),
    .imm   (imm_r),
    .cf_in (flag_cf),
    .res   (alu_s)
  );

  // Control FSM with registered ports; DX is readable but never a destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_MOV;
      dst_r       <= 3'd0;
      src_r       <= 3'd0;
      imm_r       <= 8'd0;
      opa_r       <= 8'd0;
      opb_r       <= 8'd0;
      result_r    <= 8'd0;
      req_ready   <= 1'b1;
      read_addr1  <= 3'd0;
      read_addr2  <= 3'd0;
      write_data1 <= 8'd0;
      write_data2 <= 8'd0;
      write_data3 <= 8'd0;
      we1         <= 1'b0;
      we2         <= 1'b0;
      we3         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'd0;
      rsp_err     <= 1'b0;
      flag_zf     <= 1'b0;
      flag_cf     <= 1'b0;
      flag_sf     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r      <= op_e'(req_op);
            dst_r     <= req_dst;
            src_r     <= req_src;
            imm_r     <= req_imm;
            req_ready <= 1'b0;
            if ((req_dst > REG_CX) || (req_src > REG_DX)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 8'd0;
              state_r   <= ST_RESP;
            end else begin
              read_addr1 <= req_dst;
              read_addr2 <= req_src;
              state_r    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          opa_r      <= read_data1;
          opb_r      <= read_data2;
          read_addr1 <= 3'd0;
          read_addr2 <= 3'd0;
          state_r    <= ST_EXEC;
        end
        ST_EXEC: begin
          result_r <= alu_s.data;
          flag_cf  <= alu_s.cf;
          if ((op_r != OP_MOV) && (op_r != OP_MOVI)) begin
            flag_zf <= alu_s.zf;
            flag_sf <= alu_s.sf;
          end
          case (dst_r)
            REG_AX:  begin we1 <= 1'b1; write_data1 <= alu_s.data; end
            REG_BX:  begin we2 <= 1'b1; write_data2 <= alu_s.data; end
            REG_CX:  begin we3 <= 1'b1; write_data3 <= alu_s.data; end
            default: begin we1 <= 1'b0; we2 <= 1'b0; we3 <= 1'b0; end
          endcase
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          we1         <= 1'b0;
          we2         <= 1'b0;
          we3         <= 1'b0;
          write_data1 <= 8'd0;
          write_data2 <= 8'd0;
          write_data3 <= 8'd0;
          rsp_valid   <= 1'b1;
          rsp_err     <= 1'b0;
          rsp_data    <= result_r;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 8'd0;
            req_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= 8'd0;
          we1       <= 1'b0;
          we2       <= 1'b0;
          we3       <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x86_regfile_sequencer.sv
// Directed bench for x86_regfile_sequencer with a behavioural register file
// and hand-computed expected results, flags and cycle timing.
module tb_x86_regfile_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [2:0] req_dst;
  logic [2:0] req_src;
  logic [7:0] req_imm;
  logic [2:0] read_addr1;
  logic [2:0] read_addr2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;
  logic [7:0] write_data1;
  logic [7:0] write_data2;
  logic [7:0] write_data3;
  logic       we1;
  logic       we2;
  logic       we3;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       flag_zf;
  logic       flag_cf;
  logic       flag_sf;

  logic [7:0] rf [0:7];
  int         we_cnt;
  int         n_checks;
  int         n_pass;

  x86_regfile_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_dst     (req_dst),
    .req_src     (req_src),
    .req_imm     (req_imm),
    .read_addr1  (read_addr1),
    .read_addr2  (read_addr2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .write_data1 (write_data1),
    .write_data2 (write_data2),
    .write_data3 (write_data3),
    .we1         (we1),
    .we2         (we2),
    .we3         (we3),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .flag_zf     (flag_zf),
    .flag_cf     (flag_cf),
    .flag_sf     (flag_sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];

  // Register file model; also counts cycles with any write enable high
  always @(posedge clk) begin
    if (we1) rf[0] <= write_data1;
    if (we2) rf[1] <= write_data2;
    if (we3) rf[2] <= write_data3;
    if (we1 || we2 || we3) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one op and check it cycle by cycle; flags are {zf,cf,sf}
  task automatic run_op(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [7:0] imm, input logic exp_err, input logic [7:0] exp_data,
                        input logic [2:0] exp_flags, input int stall);
    int   w0;
    logic [7:0] wd;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_op = op; req_dst = dst; req_src = src; req_imm = imm;
    req_valid = 1'b1;
    rsp_ready = (stall > 0) ? 1'b0 : 1'b1;
    w0 = we_cnt;
    @(negedge clk);  // T0+1
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 1'b0);
    if (exp_err) begin
      check("err_rsp_valid", rsp_valid, 1'b1);
      check("err_rsp_err", rsp_err, 1'b1);
      check("err_rsp_data", rsp_data, 8'h00);
    end else begin
      check("read_addr1", read_addr1, dst);
      check("read_addr2", read_addr2, src);
      check("rsp_valid_read", rsp_valid, 1'b0);
      @(negedge clk);  // T0+2
      check("we_exec", {we3, we2, we1}, 3'b000);
      @(negedge clk);  // T0+3
      check("we_write", {we3, we2, we1}, 3'b001 << dst);
      wd = (dst == 3'd0) ? write_data1 : (dst == 3'd1) ? write_data2 : write_data3;
      check("write_data", wd, exp_data);
      @(negedge clk);  // T0+4
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_err", rsp_err, 1'b0);
      check("rsp_data", rsp_data, exp_data);
      check("we_resp", {we3, we2, we1}, 3'b000);
    end
    check("flags", {flag_zf, flag_cf, flag_sf}, exp_flags);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1'b1);
      check("stall_rsp_data", rsp_data, exp_data);
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_flags", {flag_zf, flag_cf, flag_sf}, exp_flags);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", rsp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
    check("we_count", we_cnt - w0, exp_err ? 0 : 1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; we_cnt = 0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rf[3] = 8'h77;
    req_valid = 1'b0; req_op = 3'd0; req_dst = 3'd0; req_src = 3'd0; req_imm = 8'h00;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 10'd0);
    check("rst_we", {we3, we2, we1}, 3'b000);
    check("rst_wdata", {write_data1, write_data2, write_data3}, 24'd0);
    check("rst_raddr", {read_addr1, read_addr2}, 6'd0);
    check("rst_flags", {flag_zf, flag_cf, flag_sf}, 3'b000);
    rst_n = 1'b1;

    //      op    dst   src   imm    err   data   zcs     stall
    run_op(3'd1, 3'd0, 3'd0, 8'h05, 1'b0, 8'h05, 3'b000, 0);  // MOVI AX,05
    run_op(3'd1, 3'd1, 3'd0, 8'h03, 1'b0, 8'h03, 3'b000, 0);  // MOVI BX,03
    run_op(3'd1, 3'd0, 3'd0, 8'hFF, 1'b0, 8'hFF, 3'b000, 0);  // MOVI AX,FF
    run_op(3'd1, 3'd1, 3'd0, 8'h01, 1'b0, 8'h01, 3'b000, 0);  // MOVI BX,01
    run_op(3'd2, 3'd0, 3'd1, 8'h00, 1'b0, 8'h00, 3'b110, 3);  // ADD AX,BX
    run_op(3'd1, 3'd2, 3'd0, 8'h02, 1'b0, 8'h02, 3'b110, 0);  // MOVI CX,02
    run_op(3'd1, 3'd0, 3'd0, 8'h03, 1'b0, 8'h03, 3'b110, 0);  // MOVI AX,03
    run_op(3'd3, 3'd2, 3'd0, 8'h00, 1'b0, 8'hFF, 3'b011, 0);  // SUB CX,AX
    run_op(3'd7, 3'd2, 3'd0, 8'h00, 1'b0, 8'h00, 3'b110, 0);  // INC CX
    run_op(3'd0, 3'd3, 3'd0, 8'h00, 1'b1, 8'h00, 3'b110, 0);  // MOV DX,AX
    run_op(3'd4, 3'd0, 3'd1, 8'h00, 1'b0, 8'h01, 3'b000, 0);  // AND AX,BX
    run_op(3'd5, 3'd1, 3'd3, 8'h00, 1'b0, 8'h77, 3'b000, 0);  // OR BX,DX
    run_op(3'd6, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 3'b100, 0);  // XOR AX,AX
    run_op(3'd0, 3'd0, 3'd4, 8'h00, 1'b1, 8'h00, 3'b100, 0);  // MOV AX,src4
    run_op(3'd0, 3'd2, 3'd3, 8'h00, 1'b0, 8'h77, 3'b100, 0);  // MOV CX,DX
    run_op(3'd2, 3'd0, 3'd2, 8'h00, 1'b0, 8'h77, 3'b000, 0);  // ADD AX,CX
    run_op(3'd3, 3'd0, 3'd1, 8'h00, 1'b0, 8'h00, 3'b100, 0);  // SUB AX,BX

    // Reset during EXEC of ADD AX,BX (AX=00, BX=77)
    begin
      int w0;
      @(negedge clk);
      req_op = 3'd2; req_dst = 3'd0; req_src = 3'd1; req_valid = 1'b1;
      w0 = we_cnt;
      @(negedge clk);  // READ
      req_valid = 1'b0;
      @(negedge clk);  // EXEC
      rst_n = 1'b0;
      #1;
      check("mid_rst_we", {we3, we2, we1}, 3'b000);
      check("mid_rst_ready", req_ready, 1'b1);
      check("mid_rst_rsp", {rsp_valid, rsp_err, rsp_data}, 10'd0);
      check("mid_rst_flags", {flag_zf, flag_cf, flag_sf}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_no_we", we_cnt - w0, 0);
      check("mid_rst_ax", rf[0], 8'h00);
      check("mid_rst_no_rsp", rsp_valid, 1'b0);
    end
    run_op(3'd0, 3'd2, 3'd0, 8'h00, 1'b0, 8'h00, 3'b000, 0);  // MOV CX,AX
    check("final_cx", rf[2], 8'h00);
    check("final_bx", rf[1], 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/x86_regfile_sequencer.md
# x86_regfile_sequencer

Initiator-side controller for the 8-bit general register file (AX, BX, CX, DX). It accepts register-to-register and immediate micro-ops over a valid/ready request channel and drives the file's read-address and per-register write ports. It executes each op through an 8-bit ALU and returns a response carrying the result and flags. It sits between instruction decode and the register file, and is the only agent that writes the file.

## Interface
- No parameters. Widths are fixed: 8-bit data, 3-bit register address.
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high together with req_valid
- req_op  in  3  opcode: 0 MOV, 1 MOVI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 INC
- req_dst  in  3  destination register index (0 AX, 1 BX, 2 CX)
- req_src  in  3  source register index (0..3)
- req_imm  in  8  immediate operand for MOVI
- read_addr1  out  3  destination-operand address to the file
- read_addr2  out  3  source-operand address to the file
- read_data1  in  8  file data for read_addr1 (combinational)
- read_data2  in  8  file data for read_addr2 (combinational)
- write_data1  out  8  AX write data
- write_data2  out  8  BX write data
- write_data3  out  8  CX write data
- we1  out  1  AX write enable
- we2  out  1  BX write enable
- we3  out  1  CX write enable
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_data  out  8  result written, or 0 on error
- rsp_err  out  1  request rejected and nothing written
- flag_zf  out  1  zero flag (registered)
- flag_cf  out  1  carry/borrow flag (registered)
- flag_sf  out  1  sign flag (registered)

## Operation
- FSM states: IDLE, READ, EXEC, WRITE, RESP.
- IDLE: req_ready=1. On accept, latch op, dst, src and imm.
  - If req_dst>2 or req_src>3, go to RESP with rsp_err=1.
  - Otherwise go to READ.
- READ: drive read_addr1=dst and read_addr2=src. Capture read_data1 and read_data2 into operand registers at the end of the cycle. Go to EXEC.
- EXEC: compute the result in the ALU and register it. Update flags as follows, then go to WRITE.
  - MOV: result=src operand. Flags unchanged.
  - MOVI: result=imm. Flags unchanged.
  - ADD: result=dst+src. CF=carry out.
  - SUB: result=dst−src. CF=borrow (dst<src).
  - AND, OR, XOR: CF=0.
  - INC: result=dst+1. CF unchanged.
  - ZF and SF are updated from the 8-bit result for ADD, SUB, AND, OR, XOR and INC. Arithmetic is mod 256.
- WRITE: assert exactly one of we1/we2/we3 (selected by dst) for one cycle. Drive the matching write_dataN with the result. Go to RESP.
- RESP: rsp_valid=1, rsp_data=result (0 on error). Leave for IDLE on rsp_valid && rsp_ready.
- Outside READ, read_addr1 and read_addr2 are 0. Outside WRITE, all we* are 0 and all write_data* are 0.
- A DX destination is an error: the file has no DX write port.

## Timing
- Reset values: state IDLE; req_ready=1; all we* 0; write_data* 0; read_addr* 0; rsp_valid 0; rsp_data 0; rsp_err 0; all flags 0.
- Accept at edge T0:
  - READ occupies cycle T0+1.
  - EXEC occupies T0+2.
  - we pulses in T0+3; the file updates at the end of that cycle.
  - rsp_valid is first high in T0+4.
- Error path: rsp_valid is first high in T0+1, with no we pulse.
- Throughput is at most one op per 5 cycles. The next READ always follows the previous write's edge, so there is no read-after-write hazard.
- rsp_ready low in RESP: hold rsp_valid, rsp_data, rsp_err and flags stable. req_ready stays 0.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous). Any we pulse in progress is cleared, and the op is dropped with no response.
- req_* is ignored outside IDLE.

## Structure
- Package x86_regctl_pkg holds:
  - the opcode enum (op_e) and the state enum (state_e)
  - register index constants (REG_AX=0, REG_BX=1, REG_CX=2, REG_DX=3)
  - the ALU result struct {data, zf, cf, sf}
- The 8-bit ALU is a natural combinational sub-module, x86_alu8: inputs op, a, b, imm, cf_in; output the result struct.
- The FSM, operand registers and port muxing live in x86_regfile_sequencer.

## Test plan
- MOVI AX,0x05 then MOVI BX,0x03 -> we1 pulse with write_data1=0x05, then we2 pulse with 0x03. rsp_data 0x05 at T0+4, then 0x03.
- ADD AX,BX with AX=0xFF, BX=0x01 -> write_data1=0x00, ZF=1, CF=1, SF=0.
- SUB CX,AX with CX=0x02, AX=0x03 -> write_data3=0xFF, CF=1, SF=1, ZF=0. INC CX next -> 0x00, ZF=1, CF stays 1.
- MOV DX,AX -> rsp_err=1 at T0+1, rsp_data=0, no we pulse, flags unchanged.
- rsp_ready held low 3 cycles after ADD -> rsp_valid and rsp_data stable, req_ready=0; accept the next request only after the handshake.
- rst_n low during EXEC of ADD AX,BX -> no we1 pulse, all outputs at reset values; the file model shows AX unchanged.
